cache_fill_ctrl: RTL and testbench

Cache miss controller that sequences block fills for the instruction and data caches over a single shared main-memory port. Arbitrates simultaneous I/D misses, issues eight pipelined word reads per 16-byte block, steers returning words into the owning cache's data array, then writes that cache's tag/LRU/valid metadata. Sits between the two cache wrappers and the 4-cycle-latency main memory; its write strobes are what the caches consume as `write_data_array` / `write_tag_array`.

---
 rtl/cache_ctrl_pkg.sv | 18 +
 rtl/cache_fill_ctrl_if.sv | 31 +++
 rtl/fill_word_counter.sv | 25 ++
 rtl/cache_fill_ctrl.sv | 67 ++++++
 tb/tb_cache_fill_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: shared types, sizes and address helpers for the cache fill controller.
package cache_ctrl_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int BLOCK_WORDS = 8;
  localparam int MEM_LAT = 4;
  localparam int OFF_W = 4;
  localparam int CNT_W = $clog2(BLOCK_WORDS);
  typedef enum logic [1:0] {IDLE, FILL, TAG} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;
  function automatic logic [ADDR_W-1:0] block_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction
  // Byte address of 16-bit word idx inside the block starting at base.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base, input logic [CNT_W-1:0] idx);
    return {base[ADDR_W-1:OFF_W], idx, 1'b0};
  endfunction
endpackage

// File: rtl/cache_fill_ctrl_if.sv
// cache_fill_ctrl_if: cache miss, memory port and fill strobe signals of the fill controller.
interface cache_fill_ctrl_if;
  import cache_ctrl_pkg::*;
  logic icache_miss;
  logic [ADDR_W-1:0] icache_addr;
  logic dcache_miss;
  logic [ADDR_W-1:0] dcache_addr;
  logic mem_data_valid;
  logic [DATA_W-1:0] mem_data_out;
  logic mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] fill_data;
  logic [ADDR_W-1:0] fill_addr;
  logic i_write_data_array;
  logic d_write_data_array;
  logic i_write_tag_array;
  logic d_write_tag_array;
  logic i_stall;
  logic d_stall;
  logic busy;
  modport master (
    input icache_miss, icache_addr, dcache_miss, dcache_addr, mem_data_valid, mem_data_out,
    output mem_en, mem_addr, fill_data, fill_addr, i_write_data_array, d_write_data_array,
    output i_write_tag_array, d_write_tag_array, i_stall, d_stall, busy
  );
  modport slave (
    output icache_miss, icache_addr, dcache_miss, dcache_addr, mem_data_valid, mem_data_out,
    input mem_en, mem_addr, fill_data, fill_addr, i_write_data_array, d_write_data_array,
    input i_write_tag_array, d_write_tag_array, i_stall, d_stall, busy
  );
endinterface

// File: rtl/fill_word_counter.sv
// fill_word_counter: block word index that saturates at the last word and raises a sticky done flag.
module fill_word_counter
  import cache_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);
  logic last;
  assign last = cnt == CNT_W'(BLOCK_WORDS - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      done <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      done <= 1'b0;
    end else if (en && !done) begin
      cnt <= last ? cnt : cnt + 1'b1;
      done <= last;
    end
endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: I/D cache block fill sequencer over one shared pipelined memory port.
// Define CACHE_FILL_RR_EN for round-robin on simultaneous misses; default is D over I.
module cache_fill_ctrl
  import cache_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  cache_fill_ctrl_if.master bus
);
  state_t state;
  owner_t owner, grant;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0] issue_cnt, recv_cnt;
  logic issue_done, recv_done, any_miss, issue_en, recv_en, fill_end;
  assign any_miss = bus.icache_miss | bus.dcache_miss;
  assign issue_en = state == FILL && !issue_done;
  // Completion is counted in returned words, so memory may stretch its latency freely.
  assign recv_en = state == FILL && bus.mem_data_valid && !recv_done;
  assign fill_end = recv_en && recv_cnt == CNT_W'(BLOCK_WORDS - 1);
`ifdef CACHE_FILL_RR_EN
  owner_t last_grant;
  assign grant = bus.icache_miss && bus.dcache_miss ? (last_grant == OWN_I ? OWN_D : OWN_I)
               : bus.dcache_miss ? OWN_D : OWN_I;
  always_ff @(posedge clk or negedge rst)
    if (!rst) last_grant <= OWN_I;
    else if (state == IDLE && any_miss) last_grant <= grant;
`else
  assign grant = bus.dcache_miss ? OWN_D : OWN_I;
`endif
  fill_word_counter u_issue (
    .clk(clk), .rst(rst), .en(issue_en), .clr(state != FILL), .cnt(issue_cnt), .done(issue_done)
  );
  fill_word_counter u_recv (
    .clk(clk), .rst(rst), .en(recv_en), .clr(state != FILL), .cnt(recv_cnt), .done(recv_done)
  );
  assign bus.i_write_data_array = recv_en && owner == OWN_I;
  assign bus.d_write_data_array = recv_en && owner == OWN_D;
  assign bus.fill_data = recv_en ? bus.mem_data_out : '0;
  assign bus.fill_addr = recv_en ? word_addr(base, recv_cnt) : '0;
  assign bus.i_stall = bus.icache_miss | (owner == OWN_I && state != IDLE);
  assign bus.d_stall = bus.dcache_miss | (owner == OWN_D && state != IDLE);
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      owner <= OWN_I;
      base <= '0;
      bus.mem_en <= 1'b0;
      bus.mem_addr <= '0;
      bus.i_write_tag_array <= 1'b0;
      bus.d_write_tag_array <= 1'b0;
    end else begin
      bus.mem_en <= issue_en;
      bus.mem_addr <= issue_en ? word_addr(base, issue_cnt) : bus.mem_addr;
      bus.i_write_tag_array <= fill_end && owner == OWN_I;
      bus.d_write_tag_array <= fill_end && owner == OWN_D;
      case (state)
        IDLE: if (any_miss) begin
          state <= FILL;
          owner <= grant;
          base <= block_base(grant == OWN_D ? bus.dcache_addr : bus.icache_addr);
        end
        FILL: state <= fill_end ? TAG : FILL;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl: randomized fills against a block-level reference model with a scoreboard.
module tb_cache_fill_ctrl;
  import cache_ctrl_pkg::*;
  typedef struct {int cyc; logic [15:0] addr;} req_t;
  typedef struct {owner_t own; logic [15:0] addr; logic [15:0] data;} wr_t;
  typedef struct {int due; logic [15:0] addr;} mem_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  cache_fill_ctrl_if bus ();
  cache_fill_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  req_t exp_req[$];
  wr_t exp_wr[$];
  owner_t exp_tag[$];
  mem_t memq[$];
  int cyc = 0, passed = 0, total = 0, ph = 0, rcv = 0, i_tags = 0, d_tags = 0, last_due = 0, due_v = 0;
  bit gap_en = 1'b0, busy_x = 1'b0;
  owner_t own = OWN_I;
`ifdef CACHE_FILL_RR_EN
  owner_t last_own = OWN_I;
`endif
  logic [15:0] m_base, m_a;
  req_t r;
  wr_t w;
  owner_t t;
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'd40503) ^ 16'h3c5a;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, got, exp, cyc);
  endtask
  // Reference model: one fill per grant, finished by the eighth returned word, then one tag cycle.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      ph = 0;
      rcv = 0;
`ifdef CACHE_FILL_RR_EN
      last_own = OWN_I;
`endif
      exp_req.delete();
      exp_wr.delete();
      exp_tag.delete();
    end else if (ph == 0) begin
      if (bus.icache_miss || bus.dcache_miss) begin
`ifdef CACHE_FILL_RR_EN
        own = (bus.icache_miss && bus.dcache_miss) ? (last_own == OWN_I ? OWN_D : OWN_I)
            : (bus.dcache_miss ? OWN_D : OWN_I);
        last_own = own;
`else
        own = bus.dcache_miss ? OWN_D : OWN_I;
`endif
        m_base = (own == OWN_D ? bus.dcache_addr : bus.icache_addr) & 16'hfff0;
        for (int i = 0; i < 8; i++) begin
          m_a = m_base + 16'(2 * i);
          exp_req.push_back('{cyc + 1 + i, m_a});
          exp_wr.push_back('{own, m_a, mem_word(m_a)});
        end
        exp_tag.push_back(own);
        rcv = 0;
        ph = 1;
      end
    end else if (ph == 1) begin
      if (bus.mem_data_valid) begin
        rcv++;
        if (rcv == 8) ph = 2;
      end
    end else ph = 0;
  end
  // Memory: in-order pipelined reads, 4 cycles nominal, optionally stretched up to 7.
  initial begin
    bus.mem_data_valid = 1'b0;
    bus.mem_data_out = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_en) begin
        due_v = cyc + MEM_LAT + (gap_en ? int'($urandom_range(0, 3)) : 0);
        if (due_v <= last_due) due_v = last_due + 1;
        last_due = due_v;
        memq.push_back('{due_v, bus.mem_addr});
      end
      @(posedge clk);
      #1;
      if (memq.size() != 0 && memq[0].due == cyc) begin
        bus.mem_data_valid = 1'b1;
        bus.mem_data_out = mem_word(memq[0].addr);
        void'(memq.pop_front());
      end else begin
        bus.mem_data_valid = 1'b0;
        bus.mem_data_out = 16'($urandom);
      end
    end
  end
  // Monitor / scoreboard.
  always @(negedge clk) begin
    busy_x = rst && ph != 0;
    chk("busy", bus.busy, busy_x);
    chk("i_stall", bus.i_stall, bus.icache_miss | (busy_x && own == OWN_I));
    chk("d_stall", bus.d_stall, bus.dcache_miss | (busy_x && own == OWN_D));
    if (!rst)
      chk("reset_outputs", {bus.mem_en, bus.i_write_data_array, bus.d_write_data_array,
          bus.i_write_tag_array, bus.d_write_tag_array, bus.mem_addr != 0, bus.fill_addr != 0,
          bus.fill_data != 0}, 0);
    if (bus.mem_en) begin
      if (exp_req.size() == 0) chk("mem_en_extra", 1, 0);
      else begin
        r = exp_req.pop_front();
        chk("mem_addr", bus.mem_addr, r.addr);
        chk("mem_en_cycle", cyc, r.cyc);
      end
    end
    if (bus.i_write_data_array || bus.d_write_data_array) begin
      chk("wr_both", bus.i_write_data_array & bus.d_write_data_array, 0);
      if (exp_wr.size() == 0) chk("wr_extra", 1, 0);
      else begin
        w = exp_wr.pop_front();
        chk("wr_owner", {bus.i_write_data_array, bus.d_write_data_array}, {w.own == OWN_I, w.own == OWN_D});
        chk("fill_addr", bus.fill_addr, w.addr);
        chk("fill_data", bus.fill_data, w.data);
      end
    end
    if (bus.i_write_tag_array || bus.d_write_tag_array || (rst && ph == 2)) begin
      if (exp_tag.size() == 0) chk("tag_extra", 1, 0);
      else begin
        t = exp_tag.pop_front();
        chk("tag_owner", {bus.i_write_tag_array, bus.d_write_tag_array}, {t == OWN_I, t == OWN_D});
        chk("writes_before_tag", exp_wr.size(), 0);
      end
      if (bus.i_write_tag_array) i_tags++;
      if (bus.d_write_tag_array) d_tags++;
    end
  end
  // kind: 0 = I miss, 1 = D miss, 2 = both in the same cycle. Caches drop a miss once their tag is written.
  task automatic txn(input int kind, input logic [15:0] ia, input logic [15:0] da,
                     input bit gap, input bit drop, input bit do_rst);
    int n, it0, dt0;
    gap_en = gap;
    @(posedge clk);
    #1;
    it0 = i_tags;
    dt0 = d_tags;
    bus.icache_addr = ia;
    bus.dcache_addr = da;
    bus.icache_miss = kind != 1;
    bus.dcache_miss = kind != 0;
    n = 0;
    while (n < 300 && (bus.icache_miss || bus.dcache_miss || ph != 0)) begin
      @(posedge clk);
      #1;
      n++;
      if (i_tags != it0) bus.icache_miss = 1'b0;
      if (d_tags != dt0) bus.dcache_miss = 1'b0;
      if (drop && n == 3 && ph == 1) begin
        if (own == OWN_I) bus.icache_miss = 1'b0;
        else bus.dcache_miss = 1'b0;
      end
      if (do_rst && n == 7) begin
        rst = 1'b0;
        bus.icache_miss = 1'b0;
        bus.dcache_miss = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
      end
    end
    chk("txn_complete", n < 300, 1);
    n = 0;
    while (n < 50 && memq.size() != 0) begin
      @(posedge clk);
      n++;
    end
    chk("mem_drained", memq.size(), 0);
  endtask
  initial begin
    bus.icache_miss = 1'b0;
    bus.dcache_miss = 1'b0;
    bus.icache_addr = '0;
    bus.dcache_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    txn(1, 16'h0000, 16'h1234, 1'b0, 1'b0, 1'b0);
    txn(2, 16'h0040, 16'h8000, 1'b0, 1'b0, 1'b0);
    txn(2, 16'h0040, 16'h8000, 1'b0, 1'b0, 1'b0);
    txn(1, 16'h0000, 16'h2468, 1'b1, 1'b0, 1'b0);
    txn(1, 16'h0000, 16'h4410, 1'b0, 1'b0, 1'b1);
    txn(0, 16'h7772, 16'h0000, 1'b0, 1'b0, 1'b0);
    txn(1, 16'h0000, 16'h9abc, 1'b0, 1'b1, 1'b0);
    txn(2, 16'h1357, 16'hfedc, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 40; k++)
      txn(int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom), $urandom_range(0, 2) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("tag_queue_empty", exp_tag.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
  initial begin
    #600000;
    $display("FAIL timeout: simulation stalled at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
